// File: rtl/batchnorm_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// batchnorm_stream : 3-stage per-channel out = sat(((x-mean)*scale+rnd)>>>FRAC + bias)
// Optional: define BATCHNORM_RELU_EN to clamp negative results to zero.
// Revision: 1.0
// ---------------------------------------------------------------------------
module batchnorm_stream #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 8,
  parameter int CH   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [DW-1:0]      in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  output logic signed [DW-1:0]      out_data,
  output logic [$clog2(CH)-1:0]     out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      cfg_we,
  input  logic [$clog2(CH)-1:0]     cfg_addr,
  input  logic signed [CW-1:0]      cfg_mean,
  input  logic signed [CW-1:0]      cfg_scale,
  input  logic signed [CW-1:0]      cfg_bias,
  output logic                      ch_err
);
  localparam int c_CHW = $clog2(CH);
  localparam int c_SW  = ((DW > CW) ? DW : CW) + 1;
  localparam int c_PW  = c_SW + CW;
  localparam int c_RW  = c_PW + 2;

  localparam logic [c_CHW-1:0]       c_CH_TOP = c_CHW'(CH - 1);
  localparam logic [c_CHW:0]         c_CH_EXT = (c_CHW + 1)'(CH);
  localparam logic signed [CW-1:0]   c_ONE    = {{(CW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [c_RW-1:0] c_HALF   = {{(c_RW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [c_RW-1:0] c_MAX    = {{(c_RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [c_RW-1:0] c_MIN    = {{(c_RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [CW-1:0] r_mean  [CH];
  logic signed [CW-1:0] r_scale [CH];
  logic signed [CW-1:0] r_bias  [CH];

  logic [c_CHW-1:0] r_cnt;
  logic             w_adv, w_acc, w_cnt_top;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign w_acc     = in_valid && w_adv;
  assign w_cnt_top = (r_cnt == c_CH_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_mean[i]  <= '0;
        r_scale[i] <= c_ONE;
        r_bias[i]  <= '0;
      end
    end else if (cfg_we && ({1'b0, cfg_addr} < c_CH_EXT)) begin
      r_mean[cfg_addr]  <= cfg_mean;
      r_scale[cfg_addr] <= cfg_scale;
      r_bias[cfg_addr]  <= cfg_bias;
    end
  end

  // An error is flagged whenever in_last and the counter's top value disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      ch_err <= 1'b0;
    end else if (w_acc) begin
      if (in_last || w_cnt_top) r_cnt <= '0;
      else                      r_cnt <= r_cnt + 1'b1;
      if (in_last != w_cnt_top) ch_err <= 1'b1;
    end
  end

  logic signed [CW-1:0]     w_mean_rd;
  logic signed [c_SW-1:0]   w_x_ext, w_m_ext;
  logic signed [c_SW-1:0]   r_d1;
  logic signed [CW-1:0]     r_sc1, r_bi1, r_bi2;
  logic [c_CHW-1:0]         r_ch1, r_ch2;
  logic                     r_v1, r_v2;
  logic signed [c_PW-1:0]   w_d_ext, w_s_ext, w_prod, r_p2;
  logic signed [c_RW-1:0]   w_p_ext, w_b_ext, w_shf, w_res;
  logic signed [DW-1:0]     w_sat, w_out;

  assign w_mean_rd = r_mean[r_cnt];
  assign w_x_ext   = {{(c_SW-DW){in_data[DW-1]}}, in_data};
  assign w_m_ext   = {{(c_SW-CW){w_mean_rd[CW-1]}}, w_mean_rd};

  assign w_d_ext   = {{(c_PW-c_SW){r_d1[c_SW-1]}}, r_d1};
  assign w_s_ext   = {{(c_PW-CW){r_sc1[CW-1]}}, r_sc1};
  assign w_prod    = w_d_ext * w_s_ext;

  assign w_p_ext   = {{(c_RW-c_PW){r_p2[c_PW-1]}}, r_p2};
  assign w_b_ext   = {{(c_RW-CW){r_bi2[CW-1]}}, r_bi2};
  assign w_shf     = (w_p_ext + c_HALF) >>> FRAC;
  assign w_res     = w_shf + w_b_ext;

  always_comb begin
    w_sat = w_res[DW-1:0];
    if (w_res > c_MAX)      w_sat = c_MAX[DW-1:0];
    else if (w_res < c_MIN) w_sat = c_MIN[DW-1:0];
  end

`ifdef BATCHNORM_RELU_EN
  assign w_out = w_sat[DW-1] ? '0 : w_sat;
`else
  assign w_out = w_sat;
`endif

  // Whole pipeline moves as one; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_d1      <= '0;
      r_sc1     <= '0;
      r_bi1     <= '0;
      r_ch1     <= '0;
      r_v2      <= 1'b0;
      r_p2      <= '0;
      r_bi2     <= '0;
      r_ch2     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_d1  <= w_x_ext - w_m_ext;
        r_sc1 <= r_scale[r_cnt];
        r_bi1 <= r_bias[r_cnt];
        r_ch1 <= r_cnt;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p2  <= w_prod;
        r_bi2 <= r_bi1;
        r_ch2 <= r_ch1;
      end
      out_valid <= r_v2;
      if (r_v2) begin
        out_data <= w_out;
        out_ch   <= r_ch2;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/batchnorm_stream.md
BATCHNORM_STREAM -- requirements
Module: batchnorm_stream

Interface
REQ-001 Parameter DW, default 16, signed data width of input and output samples.
REQ-002 Parameter CW, default 16, signed coefficient width (mean, scale, bias).
REQ-003 Parameter FRAC, default 8, number of fractional bits in scale; FRAC >= 1.
REQ-004 Parameter CH, default 64, channel count; CH >= 2.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  DW  signed input sample, channel-interleaved (ch0..ch CH-1 per pixel).
REQ-008 in_valid / in_ready  input / output  1  input handshake; transfer when both high.
REQ-009 in_last  input  1  marks the last channel of a pixel.
REQ-010 out_data  output  DW  signed normalised sample.
REQ-011 out_ch  output  clog2(CH)  channel index of out_data.
REQ-012 out_valid / out_ready  output / input  1  output handshake.
REQ-013 cfg_we  input  1  coefficient write strobe.
REQ-014 cfg_addr  input  clog2(CH)  channel index written.
REQ-015 cfg_mean, cfg_scale, cfg_bias  input  CW each  signed coefficients for cfg_addr.
REQ-016 ch_err  output  1  sticky channel-alignment error.

Function
REQ-017 Per accepted sample on channel c: out = sat_DW(((x - mean[c]) * scale[c] + 2^(FRAC-1)) >>> FRAC + bias[c]), all intermediate arithmetic full-width signed, no overflow before saturation.
REQ-018 Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
REQ-019 Pipeline is three stages (subtract; multiply; round/shift/add/saturate); latency is exactly 3 cycles from acceptance to out_valid with out_ready held high.
REQ-020 Pipeline advances when stage-3 register is empty or out_ready is high; in_ready equals this advance condition; a stall freezes all stages with data and out_valid held stable.
REQ-021 Sustained throughput is one sample per cycle when in_valid and out_ready are continuously high.
REQ-022 Channel counter increments on each accepted sample, wraps from CH-1 to 0, and its value travels with the sample to out_ch.
REQ-023 Accepted sample with in_last high forces the counter to 0 next; if counter != CH-1 at that moment, ch_err sets.
REQ-024 Counter reaching CH-1 without in_last on that sample sets ch_err; counter still wraps to 0.
REQ-025 All three coefficients for channel c are read in the acceptance cycle and carried down the pipeline; later writes do not affect in-flight samples.
REQ-026 cfg_we in the same cycle as acceptance of the same channel: the sample uses the old coefficients; the new values apply from the next cycle.
REQ-027 cfg_addr >= CH is ignored.

Reset
REQ-028 On rst_n low: out_valid=0, out_data=0, out_ch=0, ch_err=0, channel counter=0, all pipeline valid bits cleared; in_ready=1 in the first cycle after release.
REQ-029 Coefficient storage resets to mean=0, scale=2^FRAC, bias=0 (identity transform).
REQ-030 Reset mid-stream discards all in-flight samples; no partial output is produced.

Configuration
REQ-031 Macro BATCHNORM_RELU_EN: when defined, stage 3 clamps negative results to 0 after saturation (fused ReLU); when undefined, signed saturated result is output unchanged.

Verification
REQ-032 Post-reset identity: feed x=100,-100 on ch0,ch1 -> out 100,-100 after 3 cycles, out_ch 0,1.
REQ-033 Coefficients mean=10, scale=384 (1.5), bias=-5 on ch3; x=30 -> out 25; x=-2 -> out -23 (0 with BATCHNORM_RELU_EN).
REQ-034 Saturation: mean=-32768, scale=32767, x=32767 -> out 32767; opposite sign case -> -32768.
REQ-035 Backpressure: 10 samples, out_ready toggling 1/0 every cycle -> all 10 outputs in order, none lost or duplicated, outputs stable while stalled.
REQ-036 Alignment: in_last on channel 5 with CH=64 -> ch_err=1 sticky, next sample out_ch=0; reset clears it.
REQ-037 Config hazard: cfg_we to ch0 (bias 7) in the same cycle as accepting ch0 x=0 -> out 0; next ch0 x=0 -> out 7.
